// File: rtl/pattern_detector.sv
// Serial bit-pattern detector.
// Shifts one bit of X in per clock and raises Y for one cycle whenever the
// most recent PAT_LEN bits equal PATTERN (MSB of PATTERN = oldest bit).
// A saturating count of bits received since reset stops stale or initial
// history from ever producing a match, including patterns with leading zeros.
// With OVERLAP=0 the history is cleared on a hit, so the next match needs
// PAT_LEN fresh bits.
module pattern_detector #(
    parameter int unsigned        PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter bit                 OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic X,
    output logic Y
);

    // Counter just wide enough to hold 0..PAT_LEN.
    localparam int unsigned CNT_W = (PAT_LEN < 2) ? 1 : $clog2(PAT_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PAT_LEN);

    // State registers. Declaration values give a clean power-up state that
    // matches the reset state, so an unreset instance behaves as if just reset.
    logic [PAT_LEN-1:0] hist_q = '0;
    logic [CNT_W-1:0]   cnt_q  = '0;
    logic               y_q    = 1'b0;

    logic [PAT_LEN-1:0] hist_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               y_d;

    logic [PAT_LEN-1:0] hist_shift;
    logic [CNT_W-1:0]   cnt_sat;
    logic               hit;

    // History after shifting in the current bit; a 1-bit pattern has no
    // older bits to keep, so the slice form only exists for PAT_LEN > 1.
    generate
        if (PAT_LEN == 1) begin : g_single
            assign hist_shift = X;
        end else begin : g_multi
            assign hist_shift = {hist_q[PAT_LEN-2:0], X};
        end
    endgenerate

    // Next-state logic: shift, saturate the valid count, detect, optionally restart.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the block leaves a value unassigned and no latch is inferred.
        cnt_sat = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + 1'b1;
        hit     = (cnt_sat == CNT_FULL) && (hist_shift == PATTERN);
        hist_d  = hist_shift;
        cnt_d   = cnt_sat;
        y_d     = hit;
        if (hit && !OVERLAP) begin
            hist_d = '0;
            cnt_d  = '0;
        end
    end

    // State register with synchronous reset; X is ignored on a reset edge.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            hist_q <= '0;
            cnt_q  <= '0;
            y_q    <= 1'b0;
        end else begin
            hist_q <= hist_d;
            cnt_q  <= cnt_d;
            y_q    <= y_d;
        end
    end

    // Registered detect pulse; no combinational path from X.
    assign Y = y_q;

endmodule

// File: tb/tb_pattern_detector.sv
// Directed bench for pattern_detector. Three instances share clk, reset and X:
//   dut_a : defaults (PATTERN 1011, overlapping)
//   dut_b : PATTERN 1011, non-overlapping
//   dut_c : PATTERN 0001, overlapping (leading-zero pattern)
// Expected Y values are hand-computed per step; 'x means "not checked here".
module tb_pattern_detector;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic x_in = 1'b0;
    logic y_a, y_b, y_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pattern_detector dut_a (
        .clk   (clk),
        .reset (reset),
        .X     (x_in),
        .Y     (y_a)
    );

    pattern_detector #(
        .PAT_LEN (4),
        .PATTERN (4'b1011),
        .OVERLAP (1'b0)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .X     (x_in),
        .Y     (y_b)
    );

    pattern_detector #(
        .PAT_LEN (4),
        .PATTERN (4'b0001),
        .OVERLAP (1'b1)
    ) dut_c (
        .clk   (clk),
        .reset (reset),
        .X     (x_in),
        .Y     (y_c)
    );

    task automatic check(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Drive one bit (or a reset edge), clock it in, then check each instance
    // whose expectation is not 'x.
    task automatic step(input string tag, input logic rst, input logic bit_in,
                        input logic ea, input logic eb, input logic ec);
        reset = rst;
        x_in  = bit_in;
        @(posedge clk);
        #1;
        if (ea !== 1'bx) check({tag, "/a"}, y_a, ea);
        if (eb !== 1'bx) check({tag, "/b"}, y_b, eb);
        if (ec !== 1'bx) check({tag, "/c"}, y_c, ec);
    endtask

    initial begin
        // Align to just after a rising edge.
        @(posedge clk);
        #1;

        // T1: reset held two cycles with X=1; Y must stay low.
        step("t1_rst0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("t1_rst1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // T2/T3: 0,0,0,1,0,1,1,1,0,1,1,0,1,1
        // a: hits after bits 7, 11, 14 (14 overlaps 11)
        // b: hits after bits 7, 11 only (restart after each hit)
        // c: 0001 completes at bit 4
        step("t2_b01", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t2_b02", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t2_b03", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t2_b04", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step("t2_b05", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t2_b06", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("t2_b07", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step("t2_b08", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("t2_b09", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t2_b10", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("t2_b11", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step("t2_b12", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t2_b13", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("t2_b14", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // T4: near-misses 1,0,1,0,1,0,0,1,1 -- no instance may fire.
        step("t4_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t4_b1",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("t4_b2",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t4_b3",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("t4_b4",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t4_b5",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("t4_b6",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t4_b7",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t4_b8",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("t4_b9",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // T5: 1,0,1 then reset discards progress; a trailing 1 must not hit.
        // Continuing 0,1,1 completes a fresh 1011.
        step("t5_rst0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t5_p1",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("t5_p2",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t5_p3",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("t5_rst1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("t5_n1",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("t5_n2",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t5_n3",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("t5_n4",   1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

        // T6: pattern 0001 after reset; a single 1 must not hit (cleared
        // history looks like 0001 but only one valid bit), then 0,0,0,1 hits.
        step("t6_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t6_b1",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("t6_b2",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t6_b3",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t6_b4",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t6_b5",  1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Pulse width: the hit above lasts exactly one cycle.
        step("t6_b6",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
